stream_mux_rr: RTL and testbench

//  Parametrised N:1 data multiplexer, successor to the combinational 4:1 mux.

---
 rtl/stream_mux_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/stream_mux_rr.sv | 96 +++++++++
 tb/tb_stream_mux_rr.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
//   Shared constants for the round-robin stream multiplexer.
//   ARB_RR / ARB_FIXED : arbitration mode selectors
//   sel_w(n)           : width of a channel index for n channels (min 1 bit)
// ---------------------------------------------------------------------------
package stream_mux_pkg;

   localparam int ARB_RR    = 0;  // rotating priority, pointer follows last winner
   localparam int ARB_FIXED = 1;  // lowest index always wins

   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational one-hot grant over req, searched upward from a registered
//   priority pointer with wrap-around. In fixed mode the search always
//   starts at 0. The pointer moves to (winner + 1) mod N on advance.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req       : per-channel request
//   advance   : the current grant was consumed this cycle
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted channel
// ---------------------------------------------------------------------------
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N        = 4,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic                  advance,
   output logic [N-1:0]          grant,
   output logic [sel_w(N)-1:0]   grant_idx
);

   localparam int IDX_W = sel_w(N);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] cand;
   logic             found;

   assign start = (ARB_MODE == ARB_FIXED) ? '0 : ptr_q;

   // First requester at or after start, wrapping N-1 -> 0.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      found     = 1'b0;
      for (int off = 0; off < N; off++) begin
         cand = IDX_W'((int'(start) + off) % N);
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//   N_IN:1 valid/ready stream multiplexer. An arbiter picks one valid input,
//   its word is captured into a single output register. The register can be
//   refilled in the same cycle it is drained, so full rate has no bubbles.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : per-channel valid
//   in_data   : per-channel data (unpacked array)
//   in_ready  : per-channel accept, at most one bit high, low during rst
//   out_valid : output register holds a word
//   out_data  : registered data
//   out_sel   : channel index that out_data came from
//   out_ready : consumer accepts when out_valid & out_ready
// ---------------------------------------------------------------------------
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int N_IN     = 4,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_IN-1:0]          in_valid,
   input  logic [WIDTH-1:0]         in_data [N_IN],
   output logic [N_IN-1:0]          in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [sel_w(N_IN)-1:0]   out_sel,
   input  logic                     out_ready
);

   localparam int SEL_W = sel_w(N_IN);

   logic [N_IN-1:0]  grant;
   logic [SEL_W-1:0] grant_idx;
   logic             can_load;
   logic             load;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;

   // Register is free if empty or being drained this very cycle.
   assign can_load = ~out_valid_q | out_ready;
   assign in_ready = grant & {N_IN{can_load & ~rst}};
   assign load     = |(in_valid & in_ready);

   rr_arbiter #(
      .N        (N_IN),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .advance   (load),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // NOTE: every signal gets its hold value first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[grant_idx];
         out_sel_d   = grant_idx;
      end else if (out_ready) begin
         // Drained with nothing new: data and sel keep their last value.
         out_valid_d = 1'b0;
      end
   end

   // NOTE: non-blocking assignments here, so all flops update together
   // from values computed before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
//   Drives one round-robin and one fixed-priority instance from the same
//   inputs. A queue-free behavioural model (occupancy flag, held word,
//   pointer as an integer) predicts both every cycle; directed steps add
//   literal expectations.
// ---------------------------------------------------------------------------
module tb_stream_mux_rr;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_valid;
   logic [3:0] in_data [4];
   logic       out_ready;

   logic [3:0] rr_in_ready, fp_in_ready;
   logic       rr_out_valid, fp_out_valid;
   logic [3:0] rr_out_data, fp_out_data;
   logic [1:0] rr_out_sel, fp_out_sel;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(4), .N_IN(4), .ARB_MODE(0)) dut_rr (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (rr_in_ready),
      .out_valid (rr_out_valid),
      .out_data  (rr_out_data),
      .out_sel   (rr_out_sel),
      .out_ready (out_ready)
   );

   stream_mux_rr #(.WIDTH(4), .N_IN(4), .ARB_MODE(1)) dut_fp (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (fp_in_ready),
      .out_valid (fp_out_valid),
      .out_data  (fp_out_data),
      .out_sel   (fp_out_sel),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (index 0 = RR, 1 = fixed) ----------
   logic       m_valid [2] = '{1'b0, 1'b0};
   logic [3:0] m_data  [2] = '{4'h0, 4'h0};
   int         m_sel   [2] = '{0, 0};
   int         m_ptr   [2] = '{0, 0};

   // Winner among asserted valids, counting upward from the start point.
   function automatic int winner(input int m);
      int first = (m == 0) ? m_ptr[m] : 0;
      for (int k = 0; k < 4; k++) begin
         if (in_valid[(first + k) % 4]) return (first + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready(input int m);
      logic [3:0] r = 4'b0000;
      int w = winner(m);
      if (!rst && (!m_valid[m] || out_ready) && w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         int w;
         w = winner(m);
         if (rst) begin
            m_valid[m] <= 1'b0;
            m_data[m]  <= 4'h0;
            m_sel[m]   <= 0;
            m_ptr[m]   <= 0;
         end else if (w >= 0 && (!m_valid[m] || out_ready)) begin
            m_valid[m] <= 1'b1;
            m_data[m]  <= in_data[w];
            m_sel[m]   <= w;
            m_ptr[m]   <= (w + 1) % 4;
         end else if (out_ready) begin
            m_valid[m] <= 1'b0;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("rr in_ready",  {4'h0, rr_in_ready},   {4'h0, exp_ready(0)});
      check("rr out_valid", {7'h0, rr_out_valid},  {7'h0, m_valid[0]});
      check("rr out_data",  {4'h0, rr_out_data},   {4'h0, m_data[0]});
      check("rr out_sel",   {6'h0, rr_out_sel},    8'(m_sel[0]));
      check("fp in_ready",  {4'h0, fp_in_ready},   {4'h0, exp_ready(1)});
      check("fp out_valid", {7'h0, fp_out_valid},  {7'h0, m_valid[1]});
      check("fp out_data",  {4'h0, fp_out_data},   {4'h0, m_data[1]});
      check("fp out_sel",   {6'h0, fp_out_sel},    8'(m_sel[1]));
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_abcd();
      in_data[0] = 4'hA;
      in_data[1] = 4'hB;
      in_data[2] = 4'hC;
      in_data[3] = 4'hD;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_seq [4];
      exp_seq = '{4'hA, 4'hB, 4'hC, 4'hD};

      // Reset, with every channel requesting: nothing may be accepted.
      rst       = 1'b1;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      set_abcd();
      cyc();
      cyc();
      @(negedge clk);
      check("reset in_ready",  {4'h0, rr_in_ready},  8'h00);
      check("reset out_valid", {7'h0, rr_out_valid}, 8'h00);
      check("reset out_data",  {4'h0, rr_out_data},  8'h00);
      check("reset out_sel",   {6'h0, rr_out_sel},   8'h00);
      cyc();

      // 1: single channel 2.
      rst      = 1'b0;
      in_valid = 4'b0100;
      @(negedge clk);
      check("t1 in_ready", {4'h0, rr_in_ready}, 8'h04);
      cyc();
      in_valid = 4'b0000;
      @(negedge clk);
      check("t1 out_valid", {7'h0, rr_out_valid}, 8'h01);
      check("t1 out_data",  {4'h0, rr_out_data},  8'h0C);
      check("t1 out_sel",   {6'h0, rr_out_sel},   8'h02);
      cyc();
      @(negedge clk);
      check("t1 drained", {7'h0, rr_out_valid}, 8'h00);
      check("t1 data held", {4'h0, rr_out_data}, 8'h0C);
      cyc();
      rst_pulse();

      // 2: all valid, full rate, strict rotation without bubbles.
      in_valid  = 4'hF;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc();
         @(negedge clk);
         check("t2 out_valid", {7'h0, rr_out_valid}, 8'h01);
         check("t2 out_sel",   {6'h0, rr_out_sel},   8'(k % 4));
         check("t2 out_data",  {4'h0, rr_out_data},  {4'h0, exp_seq[k % 4]});
      end

      // 3: backpressure while holding channel 3's word.
      #1;
      out_ready = 1'b0;
      #1;
      check("t3 in_ready", {4'h0, rr_in_ready}, 8'h00);
      for (int k = 0; k < 3; k++) begin
         cyc();
         @(negedge clk);
         check("t3 in_ready",  {4'h0, rr_in_ready},  8'h00);
         check("t3 out_valid", {7'h0, rr_out_valid}, 8'h01);
         check("t3 out_sel",   {6'h0, rr_out_sel},   8'h03);
         check("t3 out_data",  {4'h0, rr_out_data},  8'h0D);
      end
      #1;
      out_ready = 1'b1;
      cyc();
      @(negedge clk);
      check("t3 resume sel",  {6'h0, rr_out_sel},  8'h00);
      check("t3 resume data", {4'h0, rr_out_data}, 8'h0A);
      cyc();

      // 4: fixed priority with channels 1 and 3 held.
      rst_pulse();
      in_valid = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         cyc();
         @(negedge clk);
         check("t4 fp in_ready",  {4'h0, fp_in_ready},  8'h02);
         check("t4 fp out_valid", {7'h0, fp_out_valid}, 8'h01);
         check("t4 fp out_sel",   {6'h0, fp_out_sel},   8'h01);
         check("t4 fp out_data",  {4'h0, fp_out_data},  8'h0B);
      end
      cyc();

      // 5: unknown data on channel 3 passes through untouched.
      in_valid   = 4'b1000;
      in_data[3] = 4'bxxxx;
      cyc();
      @(negedge clk);
      check("t5 out_data", {4'h0, rr_out_data}, {4'h0, 4'bxxxx});
      check("t5 out_sel",  {6'h0, rr_out_sel},  8'h03);
      cyc();
      in_data[3] = 4'hD;
      in_valid   = 4'b0000;
      cyc();

      // 6: reset while a word is held and the pointer sits at 2.
      rst_pulse();
      in_valid = 4'b0010;
      cyc();
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      cyc();
      @(negedge clk);
      check("t6 held valid", {7'h0, rr_out_valid}, 8'h01);
      check("t6 held sel",   {6'h0, rr_out_sel},   8'h01);
      #1;
      rst      = 1'b1;
      in_valid = 4'hF;
      #1;
      check("t6 rst in_ready", {4'h0, rr_in_ready}, 8'h00);
      cyc();
      @(negedge clk);
      check("t6 out_valid", {7'h0, rr_out_valid}, 8'h00);
      check("t6 out_data",  {4'h0, rr_out_data},  8'h00);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      cyc();
      @(negedge clk);
      check("t6 first valid", {7'h0, rr_out_valid}, 8'h01);
      check("t6 first sel",   {6'h0, rr_out_sel},   8'h00);
      check("t6 first data",  {4'h0, rr_out_data},  8'h0A);
      cyc();
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
